// File: rtl/rob_pkg.sv
// rob_pkg: shared reorder-buffer entry type and tag/index helpers.
// Tags run 1..ROBsize, and map value 0 means "not renamed", so an entry's tag is its index plus one.
package rob_pkg;
    localparam int ROB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  regWrite;
        logic [4:0]            destReg;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

    function automatic int tag2idx(input int tag);
        return tag - 1;
    endfunction

    function automatic int idx2tag(input int idx);
        return idx + 1;
    endfunction
endpackage

// File: rtl/decoder5x32.sv
// decoder5x32: 5-to-32 one-hot decoder with enable; the output is all zeros when en is low.
module decoder5x32 (
    input  logic [4:0]  addr,
    input  logic        en,
    output logic [31:0] y
);
    assign y = en ? (32'd1 << addr) : 32'd0;
endmodule

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: circular reorder buffer with in-order commit.
// It drives the architectural register file write and the map-table commit interface.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int ROBsize      = 32,
    parameter int mapValueSize = $clog2(ROBsize + 1),
    parameter int DATA_W       = ROB_DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alloc_valid_i,
    input  logic                    alloc_regWrite_i,
    input  logic [4:0]              alloc_destReg_i,
    output logic                    alloc_ready_o,
    output logic [mapValueSize-1:0] alloc_tag_o,
    input  logic                    wb_valid_i,
    input  logic [mapValueSize-1:0] wb_tag_i,
    input  logic [DATA_W-1:0]       wb_data_i,
    input  logic [mapValueSize-1:0] robReadTag1_i,
    input  logic [mapValueSize-1:0] robReadTag2_i,
    output logic [DATA_W-1:0]       robReadData1_o,
    output logic [DATA_W-1:0]       robReadData2_o,
    output logic                    robReadDone1_o,
    output logic                    robReadDone2_o,
    output logic [4:0]              commitReadAddr_o,
    input  logic [mapValueSize-1:0] commitReadData_i,
    output logic [31:0]             resets_o,
    output logic                    rf_write_o,
    output logic [4:0]              rf_writeAddr_o,
    output logic [DATA_W-1:0]       rf_writeData_o,
    output logic                    empty_o,
    output logic [mapValueSize-1:0] count_o
);
    localparam int IW = $clog2(ROBsize);

    rob_entry_t              rob [ROBsize];
    rob_entry_t              hd, rd1, rd2;
    logic [IW-1:0]           head, tail, head_nxt, tail_nxt, wb_idx, rd1_idx, rd2_idx;
    logic [mapValueSize-1:0] count, head_tag;
    logic                    alloc, commit, wb_hit, rd1_ok, rd2_ok;

    function automatic logic tag_ok(input logic [mapValueSize-1:0] t);
        return (t != '0) && (int'(t) <= ROBsize);
    endfunction

    assign hd       = rob[head];
    assign head_tag = mapValueSize'(idx2tag(int'(head)));
    assign head_nxt = (head == IW'(ROBsize - 1)) ? '0 : head + 1'b1;
    assign tail_nxt = (tail == IW'(ROBsize - 1)) ? '0 : tail + 1'b1;

    assign alloc_ready_o = count != mapValueSize'(ROBsize);
    assign alloc_tag_o   = mapValueSize'(idx2tag(int'(tail)));
    assign alloc         = alloc_valid_i & alloc_ready_o;
    assign commit        = hd.valid & hd.done;
    assign empty_o       = count == '0;
    assign count_o       = count;

    // Writebacks to free slots or out-of-range tags are dropped.
    assign wb_idx = IW'(tag2idx(int'(wb_tag_i)));
    assign wb_hit = wb_valid_i && tag_ok(wb_tag_i) && rob[wb_idx].valid;

    assign rd1_idx        = IW'(tag2idx(int'(robReadTag1_i)));
    assign rd2_idx        = IW'(tag2idx(int'(robReadTag2_i)));
    assign rd1            = rob[rd1_idx];
    assign rd2            = rob[rd2_idx];
    assign rd1_ok         = tag_ok(robReadTag1_i);
    assign rd2_ok         = tag_ok(robReadTag2_i);
    assign robReadDone1_o = rd1_ok & rd1.valid & rd1.done;
    assign robReadDone2_o = rd2_ok & rd2.valid & rd2.done;
    assign robReadData1_o = rd1_ok ? rd1.data : '0;
    assign robReadData2_o = rd2_ok ? rd2.data : '0;

    assign commitReadAddr_o = hd.destReg;
    assign rf_write_o       = commit & hd.regWrite;
    assign rf_writeAddr_o   = hd.destReg;
    assign rf_writeData_o   = hd.data;

    // Clear the map entry only if it still points at the retiring tag.
    decoder5x32 u_dec (
        .addr (hd.destReg),
        .en   (rf_write_o & (commitReadData_i == head_tag)),
        .y    (resets_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROBsize; i++) rob[i] <= '0;
        end else begin
            if (alloc) begin
                rob[tail].valid    <= 1'b1;
                rob[tail].done     <= 1'b0;
                rob[tail].regWrite <= alloc_regWrite_i;
                rob[tail].destReg  <= alloc_destReg_i;
                rob[tail].data     <= '0;
                tail               <= tail_nxt;
            end
            if (wb_hit) begin
                rob[wb_idx].done <= 1'b1;
                rob[wb_idx].data <= wb_data_i;
            end
            if (commit) begin
                rob[head].valid <= 1'b0;
                head            <= head_nxt;
            end
            count <= (alloc && !commit) ? count + 1'b1 :
                     (!alloc && commit) ? count - 1'b1 : count;
        end
    end
endmodule
